pattern_generator_param: RTL and testbench

Parametrised next-generation test-pattern generator that drives a raster of pixel values into the downstream video datapath for RTL bring-up and verification. Frame start is `f_sync` and line start is `sync`. Data width, raster size and ramp step width are parameters. Mode, constant value and deltas are latched once per frame, which adds frame/line tracking, saturating arithmetic, checkerboard and PRBS modes, and explicit valid/done/error status.

---
 rtl/pattern_generator_param.sv | 169 ++++++++++++++++
 tb/tb_pattern_generator_param.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_generator_param.sv
// Raster test-pattern generator: constant, X/Y/XY ramps, checkerboard and PRBS.
// Configuration is latched on f_sync, and each sync while the frame is armed emits one line of H_ACTIVE pixels.
module pattern_generator_param #(
   parameter int unsigned DATA_W     = 12,
   parameter int unsigned DELTA_W    = 2,
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned CHECK_LOG2 = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_sync,
   input  logic              sync,
   input  logic [DATA_W-1:0] constVal,
   input  logic [DELTA_W-1:0] X,
   input  logic [DELTA_W-1:0] Y,
   input  logic [2:0]        Mode,
   input  logic              sat_en,
   output logic [DATA_W-1:0] cnt,
   output logic              pix_valid,
   output logic              frame_done,
   output logic              mode_err
);

   localparam int unsigned STEP_MAX = (1 << DELTA_W) - 1;
   localparam int unsigned ACC_MAX  = ((1 << DATA_W) - 1) + (H_ACTIVE - 1) * STEP_MAX
                                      + (V_ACTIVE - 1) * STEP_MAX;
   localparam int unsigned ACC_W    = $clog2(ACC_MAX + 1);
   localparam int unsigned COL_W    = $clog2(H_ACTIVE);
   localparam int unsigned ROW_W    = $clog2(V_ACTIVE);
   localparam logic [ACC_W-1:0] FULL_SCALE = ACC_W'((1 << DATA_W) - 1);
   localparam logic [15:0] LFSR_INIT = 16'hACE1;

   localparam logic [2:0] M_CONST    = 3'd0;
   localparam logic [2:0] M_RAMP_X   = 3'd1;
   localparam logic [2:0] M_RAMP_Y   = 3'd2;
   localparam logic [2:0] M_RAMP_XY  = 3'd3;
   localparam logic [2:0] M_CHECKER  = 3'd4;
   localparam logic [2:0] M_PRBS     = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_ACTIVE
   } state_t;

   state_t             state;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [ACC_W-1:0]   row_base;
   logic [ACC_W-1:0]   acc;
   logic [15:0]        lfsr;

   logic [2:0]         cfg_mode;
   logic [DATA_W-1:0]  cfg_const;
   logic [DELTA_W-1:0] cfg_dx;
   logic [DELTA_W-1:0] cfg_dy;
   logic               cfg_sat;

   logic [COL_W-1:0]   emit_col;
   logic [ACC_W-1:0]   emit_acc;
   logic [DATA_W-1:0]  pix_next;
   logic               chk_bit;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   // Ramps are carried as an exact running sum: row_base steps by dy per line,
   // acc steps by dx per pixel; modes that ignore an axis latch a zero step.
   always_comb begin
      emit_col = '0;
      emit_acc = row_base;
      pix_next = '0;
      chk_bit  = 1'b0;
      if (state == S_ACTIVE) begin
         emit_col = col + COL_W'(1);
         emit_acc = acc + ACC_W'(cfg_dx);
      end
      chk_bit = (((32'(emit_col) >> CHECK_LOG2) ^ (32'(row) >> CHECK_LOG2)) & 32'd1) != 32'd0;
      case (cfg_mode)
         M_CONST, M_RAMP_X, M_RAMP_Y, M_RAMP_XY: begin
            if (cfg_sat && (emit_acc > FULL_SCALE))
               pix_next = '1;
            else
               pix_next = emit_acc[DATA_W-1:0];
         end
         M_CHECKER: pix_next = chk_bit ? ~cfg_const : cfg_const;
         M_PRBS:    pix_next = lfsr[DATA_W-1:0];
         default:   pix_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         col        <= '0;
         row        <= '0;
         row_base   <= '0;
         acc        <= '0;
         lfsr       <= LFSR_INIT;
         cfg_mode   <= M_CONST;
         cfg_const  <= '0;
         cfg_dx     <= '0;
         cfg_dy     <= '0;
         cfg_sat    <= 1'b0;
         cnt        <= '0;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         mode_err   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (f_sync) begin
            // f_sync overrides any same-cycle sync and aborts a line in progress
            state     <= S_ARMED;
            col       <= '0;
            row       <= '0;
            acc       <= '0;
            cfg_mode  <= Mode;
            cfg_const <= constVal;
            cfg_sat   <= sat_en;
            cfg_dx    <= ((Mode == M_RAMP_X) || (Mode == M_RAMP_XY)) ? X : '0;
            cfg_dy    <= ((Mode == M_RAMP_Y) || (Mode == M_RAMP_XY)) ? Y : '0;
            row_base  <= ACC_W'(constVal);
            lfsr      <= (constVal == '0) ? LFSR_INIT : 16'(constVal);
            mode_err  <= (Mode > M_PRBS);
            cnt       <= '0;
            pix_valid <= 1'b0;
         end else begin
            case (state)
               S_ARMED: begin
                  if (sync) begin
                     state     <= S_ACTIVE;
                     col       <= '0;
                     acc       <= emit_acc;
                     cnt       <= pix_next;
                     pix_valid <= 1'b1;
                     if (cfg_mode == M_PRBS)
                        lfsr <= lfsr_step(lfsr);
                  end
               end
               S_ACTIVE: begin
                  if (col == COL_W'(H_ACTIVE - 1)) begin
                     col       <= '0;
                     cnt       <= '0;
                     pix_valid <= 1'b0;
                     if (row == ROW_W'(V_ACTIVE - 1)) begin
                        state      <= S_IDLE;
                        frame_done <= 1'b1;
                     end else begin
                        state    <= S_ARMED;
                        row      <= row + ROW_W'(1);
                        row_base <= row_base + ACC_W'(cfg_dy);
                     end
                  end else begin
                     col <= emit_col;
                     acc <= emit_acc;
                     cnt <= pix_next;
                     if (cfg_mode == M_PRBS)
                        lfsr <= lfsr_step(lfsr);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pattern_generator_param.sv
// Bench for pattern_generator_param: directed pattern checks with literal values,
// then randomized traffic compared every cycle against a pixel-coordinate model.
module tb_pattern_generator_param;

   localparam int DW   = 8;
   localparam int DLW  = 2;
   localparam int H    = 4;
   localparam int V    = 3;
   localparam int CL   = 1;
   localparam int MAXV = (1 << DW) - 1;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           f_sync = 1'b0;
   logic           sync = 1'b0;
   logic [DW-1:0]  constVal = '0;
   logic [DLW-1:0] X = '0;
   logic [DLW-1:0] Y = '0;
   logic [2:0]     Mode = '0;
   logic           sat_en = 1'b0;
   logic [DW-1:0]  cnt;
   logic           pix_valid;
   logic           frame_done;
   logic           mode_err;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   int   line_px[H];
   logic line_done;
   logic line_valid_after;

   always #8 clk = ~clk;

   pattern_generator_param #(
      .DATA_W(DW), .DELTA_W(DLW), .H_ACTIVE(H), .V_ACTIVE(V), .CHECK_LOG2(CL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .f_sync(f_sync), .sync(sync),
      .constVal(constVal), .X(X), .Y(Y), .Mode(Mode), .sat_en(sat_en),
      .cnt(cnt), .pix_valid(pix_valid), .frame_done(frame_done), .mode_err(mode_err)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: pixel values from their (col,row) coordinates
   int m_mode = 0, m_const = 0, m_x = 0, m_y = 0;
   bit m_sat = 0, m_open = 0, m_in_line = 0;
   int m_row = 0, m_col = 0;
   int m_lfsr = 'hACE1;
   int e_cnt = 0;
   bit e_valid = 0, e_done = 0, e_err = 0;

   function automatic int lfsr_next(input int s);
      int b;
      b = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
      return (s >> 1) | (b << 15);
   endfunction

   function automatic int exp_pixel(input int c, input int r);
      int v;
      v = 0;
      case (m_mode)
         0, 1, 2, 3: begin
            v = m_const;
            if (m_mode == 1 || m_mode == 3) v += c * m_x;
            if (m_mode == 2 || m_mode == 3) v += r * m_y;
            if (m_sat) v = (v > MAXV) ? MAXV : v;
            else       v = v % (MAXV + 1);
         end
         4: v = ((((c >> CL) ^ (r >> CL)) & 1) != 0) ? (~m_const & MAXV) : m_const;
         default: v = 0;
      endcase
      return v;
   endfunction

   task automatic model_emit();
      e_valid = 1'b1;
      if (m_mode == 5) begin
         e_cnt  = m_lfsr & MAXV;
         m_lfsr = lfsr_next(m_lfsr);
      end else begin
         e_cnt = exp_pixel(m_col, m_row);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_open = 0; m_in_line = 0; m_row = 0; m_col = 0; m_lfsr = 'hACE1;
         e_cnt = 0; e_valid = 0; e_done = 0; e_err = 0;
      end else begin
         e_done = 0;
         if (f_sync) begin
            m_mode = int'(Mode); m_const = int'(constVal); m_x = int'(X); m_y = int'(Y);
            m_sat = sat_en;
            m_lfsr = (constVal == 0) ? 'hACE1 : int'(constVal);
            m_open = 1; m_in_line = 0; m_row = 0;
            e_valid = 0; e_cnt = 0; e_err = (Mode >= 6);
         end else if (m_in_line) begin
            if (m_col == H - 1) begin
               m_in_line = 0; e_valid = 0; e_cnt = 0;
               if (m_row == V - 1) begin
                  m_open = 0; e_done = 1;
               end else begin
                  m_row++;
               end
            end else begin
               m_col++;
               model_emit();
            end
         end else if (m_open && sync) begin
            m_in_line = 1; m_col = 0;
            model_emit();
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmp_pix_valid", pix_valid, e_valid);
         check("cmp_cnt", cnt, e_cnt);
         check("cmp_frame_done", frame_done, e_done);
         check("cmp_mode_err", mode_err, e_err);
      end
   end

   // Called at a negedge; returns at the next negedge with the frame armed.
   // Inputs are scrambled afterwards to show the latched configuration is used.
   task automatic frame_start(input int md, input int cv, input int x, input int y, input bit sat);
      Mode = 3'(md); constVal = DW'(cv); X = DLW'(x); Y = DLW'(y); sat_en = sat;
      f_sync = 1'b1;
      @(negedge clk);
      f_sync = 1'b0;
      Mode = 3'($urandom); constVal = DW'($urandom); X = DLW'($urandom);
      Y = DLW'($urandom); sat_en = 1'($urandom);
   endtask

   task automatic run_line(input bit hold);
      sync = 1'b1;
      @(negedge clk);
      if (!hold) sync = 1'b0;
      for (int i = 0; i < H; i++) begin
         if (i > 0) @(negedge clk);
         if (i == H - 1) sync = 1'b0;
         line_px[i] = pix_valid ? int'(cnt) : -1;
      end
      @(negedge clk);
      line_done = frame_done;
      line_valid_after = pix_valid;
      @(negedge clk);
   endtask

   task automatic check_line(input string name, input int p0, input int p1, input int p2, input int p3);
      check({name, "_px0"}, line_px[0], p0);
      check({name, "_px1"}, line_px[1], p1);
      check({name, "_px2"}, line_px[2], p2);
      check({name, "_px3"}, line_px[3], p3);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cnt", cnt, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_mode_err", mode_err, 0);
      rst_n = 1'b1;
      cmp_en = 1'b1;
      @(negedge clk);

      // X ramp over a full frame
      frame_start(1, 10, 3, 0, 0);
      for (int r = 0; r < V; r++) begin
         run_line(1'b0);
         check_line("rampx", 10, 13, 16, 19);
         check("rampx_frame_done", line_done, (r == V - 1) ? 1 : 0);
         check("rampx_gap_valid", line_valid_after, 0);
      end

      // XY ramp with clamping, then with wrap
      frame_start(3, 250, 2, 1, 1);
      run_line(1'b0);
      check_line("sat_l0", 250, 252, 254, 255);
      run_line(1'b0);
      check_line("sat_l1", 251, 253, 255, 255);
      frame_start(3, 250, 2, 1, 0);
      run_line(1'b0);
      check_line("wrap_l0", 250, 252, 254, 0);
      run_line(1'b0);
      check_line("wrap_l1", 251, 253, 255, 1);

      // Checkerboard with 2x2 squares
      frame_start(4, 'hF0, 0, 0, 0);
      run_line(1'b0);
      check_line("chk_r0", 'hF0, 'hF0, 'h0F, 'h0F);
      run_line(1'b0);
      check_line("chk_r1", 'hF0, 'hF0, 'h0F, 'h0F);
      run_line(1'b0);
      check_line("chk_r2", 'h0F, 'h0F, 'hF0, 'hF0);

      // PRBS from the default seed, reseeded by a second f_sync
      for (int f = 0; f < 2; f++) begin
         frame_start(5, 0, 0, 0, 0);
         run_line(1'b0);
         check_line("prbs_l0", 'hE1, 'h70, 'h38, 'h9C);
         run_line(1'b0);
      end

      // Reserved mode
      frame_start(6, 77, 1, 1, 1);
      check("merr_set", mode_err, 1);
      run_line(1'b0);
      check_line("merr_zero", 0, 0, 0, 0);
      frame_start(0, 33, 0, 0, 0);
      check("merr_clear", mode_err, 0);

      // sync together with f_sync starts no line
      Mode = 3'd0; constVal = 8'd9; sat_en = 1'b0;
      f_sync = 1'b1; sync = 1'b1;
      @(negedge clk);
      f_sync = 1'b0; sync = 1'b0;
      check("fsync_sync_valid0", pix_valid, 0);
      @(negedge clk);
      check("fsync_sync_valid1", pix_valid, 0);
      run_line(1'b0);
      check_line("fsync_sync_line", 9, 9, 9, 9);

      // Mid-line f_sync aborts the line and restarts at row 0
      frame_start(2, 5, 0, 3, 0);
      run_line(1'b0);
      check_line("yramp_r0", 5, 5, 5, 5);
      run_line(1'b0);
      check_line("yramp_r1", 8, 8, 8, 8);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      check("abort_px0", cnt, 11);
      @(negedge clk);
      Mode = 3'd2; constVal = 8'd5; X = 2'd0; Y = 2'd3; sat_en = 1'b0;
      f_sync = 1'b1;
      @(negedge clk);
      f_sync = 1'b0;
      check("abort_valid_drop", pix_valid, 0);
      check("abort_no_done", frame_done, 0);
      run_line(1'b0);
      check_line("abort_row_reset", 5, 5, 5, 5);

      // sync held through the line is ignored while active
      run_line(1'b1);
      check_line("extra_sync", 8, 8, 8, 8);
      check("extra_sync_no_done", line_done, 0);
      run_line(1'b0);
      check("last_line_done", line_done, 1);

      // sync after the frame has ended is ignored
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      check("idle_sync0", pix_valid, 0);
      @(negedge clk);
      check("idle_sync1", pix_valid, 0);

      // Asynchronous reset mid-line
      frame_start(1, 10, 3, 0, 0);
      sync = 1'b1;
      @(negedge clk);
      sync = 1'b0;
      @(negedge clk);
      check("pre_reset_valid", pix_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_cnt", cnt, 0);
      check("async_rst_valid", pix_valid, 0);
      check("async_rst_err", mode_err, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Randomized traffic checked by the model on every cycle
      for (int cyc = 0; cyc < 3000; cyc++) begin
         Mode = 3'($urandom);
         case ($urandom_range(0, 3))
            0:       constVal = '0;
            1:       constVal = DW'(240 + $urandom_range(0, 15));
            default: constVal = DW'($urandom);
         endcase
         X = DLW'($urandom);
         Y = DLW'($urandom);
         sat_en = 1'($urandom);
         f_sync = ($urandom_range(0, 39) == 0);
         sync = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      f_sync = 1'b0;
      sync = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
